// File: rtl/vec3_stb_collector_pkg.sv
// Shared constants and lane naming for the 3-lane vector collector.
// Imported by the collector top and its lane buffer.
package vec3_stb_collector_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 2;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        LANE_X = 2'd0,
        LANE_Y = 2'd1,
        LANE_Z = 2'd2
    } lane_e;

endpackage

// File: rtl/vec3_stb_collector_if.sv
// Producer-lane and vector-consumer handshake bundle.
// slave = collector side, master = producers/consumer side.
interface vec3_stb_collector_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_z0;
    logic [WIDTH-1:0] in_z1;
    logic [WIDTH-1:0] in_z2;
    logic             in_z_stb0;
    logic             in_z_stb1;
    logic             in_z_stb2;
    logic             in_z_ack0;
    logic             in_z_ack1;
    logic             in_z_ack2;
    logic [WIDTH-1:0] vec_x;
    logic [WIDTH-1:0] vec_y;
    logic [WIDTH-1:0] vec_z;
    logic             vec_stb;
    logic             vec_ack;
    logic             timeout_err;

    modport slave (
        input  in_z0, in_z1, in_z2,
        input  in_z_stb0, in_z_stb1, in_z_stb2,
        output in_z_ack0, in_z_ack1, in_z_ack2,
        output vec_x, vec_y, vec_z, vec_stb,
        input  vec_ack,
        output timeout_err
    );

    modport master (
        output in_z0, in_z1, in_z2,
        output in_z_stb0, in_z_stb1, in_z_stb2,
        input  in_z_ack0, in_z_ack1, in_z_ack2,
        input  vec_x, vec_y, vec_z, vec_stb,
        output vec_ack,
        input  timeout_err
    );
endinterface

// File: rtl/stb_lane_fifo.sv
// One producer lane buffer: DEPTH-entry FIFO with level counter.
// Ack is decoded from the registered level only.
module stb_lane_fifo
    import vec3_stb_collector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             CLK2,
    input  logic             RST,
    input  logic             stb_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             ack_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    lvl_q, lvl_d;
    logic             push;

    assign ack_o   = (lvl_q != LW'(DEPTH));
    assign valid_o = (lvl_q != '0);
    assign push    = stb_i & ack_o;
    assign data_o  = mem_q[rptr_q];

    // Pointer and level next-state; pop is only issued when non-empty.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        lvl_d  = lvl_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop_i) rptr_d = rptr_q + 1'b1;
        if (push && !pop_i) lvl_d = lvl_q + 1'b1;
        if (!push && pop_i) lvl_d = lvl_q - 1'b1;
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            lvl_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            lvl_q  <= lvl_d;
        end
    end

    // Storage needs no reset; it is only read behind valid_o.
    always_ff @(posedge CLK2) begin
        if (push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/vec3_stb_collector.sv
// Collects one word per lane into a 3-vector and pops all lanes together.
// Optional lane-skew watchdog: define VEC3_COLLECT_TIMEOUT_EN.
module vec3_stb_collector
    import vec3_stb_collector_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                 CLK2,
    input logic                 RST,
    vec3_stb_collector_if.slave bus
);
    logic [2:0]       stb;
    logic [2:0]       ack;
    logic [2:0]       vld;
    logic [WIDTH-1:0] din  [3];
    logic [WIDTH-1:0] head [3];
    logic             vec_stb;
    logic             pop;

    assign stb[LANE_X] = bus.in_z_stb0;
    assign stb[LANE_Y] = bus.in_z_stb1;
    assign stb[LANE_Z] = bus.in_z_stb2;
    assign din[LANE_X] = bus.in_z0;
    assign din[LANE_Y] = bus.in_z1;
    assign din[LANE_Z] = bus.in_z2;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        stb_lane_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .CLK2   (CLK2),
            .RST    (RST),
            .stb_i  (stb[i]),
            .data_i (din[i]),
            .pop_i  (pop),
            .ack_o  (ack[i]),
            .valid_o(vld[i]),
            .data_o (head[i])
        );
    end

    assign vec_stb = &vld;
    assign pop     = vec_stb & bus.vec_ack;

    assign bus.in_z_ack0 = ack[LANE_X];
    assign bus.in_z_ack1 = ack[LANE_Y];
    assign bus.in_z_ack2 = ack[LANE_Z];
    assign bus.vec_stb   = vec_stb;
    assign bus.vec_x     = vec_stb ? head[LANE_X] : '0;
    assign bus.vec_y     = vec_stb ? head[LANE_Y] : '0;
    assign bus.vec_z     = vec_stb ? head[LANE_Z] : '0;

`ifdef VEC3_COLLECT_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    // Count cycles spent partially collected; saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (vec_stb || !(|vld)) cnt_d = '0;
        else if (cnt_q != TO_LIM) cnt_d = cnt_q + 16'd1;
        err_d = err_q | (cnt_d == TO_LIM);
    end

    // Watchdog state; the error stays set until reset.
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule
